// File: rtl/nonce_dispatch_if.sv
// nonce_dispatch_if: golden-nonce valid/ready stream from the dispatcher to its consumer
interface nonce_dispatch_if #(parameter int NONCE_BITS = 32);
   logic                  gn_valid;
   logic [NONCE_BITS-1:0] gn_nonce;
   logic                  gn_ready;
   modport master(output gn_valid, gn_nonce, input gn_ready);
   modport slave(input gn_valid, gn_nonce, output gn_ready);
endinterface

// File: rtl/nonce_dispatch_ctrl.sv
// nonce_dispatch_ctrl: splits the nonce space across hasher lanes and queues latency-compensated golden nonces
module nonce_dispatch_ctrl #(
   parameter int          NUM_CORES    = 2,
   parameter int          NONCE_BITS   = 32,
   parameter int          PIPE_LATENCY = 254,
   parameter int          FIFO_DEPTH   = 4,
   parameter logic [31:0] MATCH_VALUE  = 32'hA41F32E7
) (
   input  logic                            hash_clk,
   input  logic                            reset,
   input  logic                            new_work,
   input  logic [255:0]                    work_midstate,
   input  logic [95:0]                     work_data,
   output logic [255:0]                    core_midstate,
   output logic [95:0]                     core_data,
   output logic [NONCE_BITS*NUM_CORES-1:0] core_nonce,
   input  logic [32*NUM_CORES-1:0]         core_hash2,
   nonce_dispatch_if.master                gn,
   output logic                            running,
   output logic                            exhausted,
   output logic                            overflow
);
   localparam int LB = $clog2(NUM_CORES);
   localparam int CW = NONCE_BITS - LB;
   localparam int DW = $clog2(PIPE_LATENCY + 1);
   localparam int AW = $clog2(FIFO_DEPTH);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   state_t state, state_nxt;
   logic [CW-1:0] cnt, rcnt, hit_cnt;
   logic [DW-1:0] dcnt;
   logic [PIPE_LATENCY-1:0] vld_sr;
   logic [NUM_CORES-1:0] hit_reg, slot_full, move;
   logic [NONCE_BITS-1:0] slot_nonce [NUM_CORES];
   logic [NONCE_BITS-1:0] mem [FIFO_DEPTH];
   logic [NONCE_BITS-1:0] push_nonce;
   logic [AW:0] wptr, rptr;
   logic last_cnt, drain_done, res_vld, fifo_full, push, pop;
   assign last_cnt   = &cnt;
   assign drain_done = dcnt == DW'(PIPE_LATENCY);
   assign running    = state != IDLE;
   assign res_vld    = vld_sr[PIPE_LATENCY-1];
   assign fifo_full  = (wptr ^ rptr) == {1'b1, {AW{1'b0}}};
   assign push       = |move;
   assign pop        = gn.gn_valid && gn.gn_ready;
   assign gn.gn_valid = wptr != rptr;
   assign gn.gn_nonce = gn.gn_valid ? mem[rptr[AW-1:0]] : '0;
   for (genvar k = 0; k < NUM_CORES; k++) begin : g_lane
      assign core_nonce[k*NONCE_BITS +: NONCE_BITS] = (NONCE_BITS'(cnt) << LB) | NONCE_BITS'(k);
   end
   always_comb begin
      state_nxt = new_work ? RUN :
                  (state == RUN && last_cnt) ? DRAIN :
                  (state == DRAIN && drain_done) ? IDLE : state;
   end
   // lowest-index full slot wins the single FIFO write port
   always_comb begin
      move = '0;
      push_nonce = '0;
      for (int k = NUM_CORES - 1; k >= 0; k--)
         if (slot_full[k] && !fifo_full) begin
            move = NUM_CORES'(1) << k;
            push_nonce = slot_nonce[k];
         end
   end
   always_ff @(posedge hash_clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt <= '0;
         dcnt <= '0;
         core_midstate <= '0;
         core_data <= '0;
         exhausted <= 1'b0;
      end else begin
         state <= state_nxt;
         if (new_work) begin
            cnt <= '0;
            dcnt <= '0;
            core_midstate <= work_midstate;
            core_data <= work_data;
            exhausted <= 1'b0;
         end else begin
            if (state == RUN && !last_cnt) cnt <= cnt + CW'(1);
            if (state == DRAIN) dcnt <= dcnt + DW'(1);
            if (state == DRAIN && drain_done) exhausted <= 1'b1;
         end
      end
   end
   // rcnt counts valid results in issue order, so it equals the cnt that produced each hash
   always_ff @(posedge hash_clk or posedge reset) begin
      if (reset) begin
         vld_sr <= '0;
         rcnt <= '0;
         hit_cnt <= '0;
         hit_reg <= '0;
         slot_full <= '0;
         overflow <= 1'b0;
         wptr <= '0;
         rptr <= '0;
      end else if (new_work) begin
         vld_sr <= '0;
         rcnt <= '0;
         hit_cnt <= '0;
         hit_reg <= '0;
         slot_full <= '0;
         overflow <= 1'b0;
         wptr <= '0;
         rptr <= '0;
      end else begin
         vld_sr <= PIPE_LATENCY'({vld_sr, state == RUN});
         if (res_vld) rcnt <= rcnt + CW'(1);
         hit_cnt <= rcnt;
         for (int k = 0; k < NUM_CORES; k++) begin
            hit_reg[k] <= res_vld && core_hash2[32*k +: 32] == MATCH_VALUE;
            if (hit_reg[k] && slot_full[k] && !move[k]) overflow <= 1'b1;
            else if (hit_reg[k] || move[k]) slot_full[k] <= hit_reg[k];
         end
         if (push) wptr <= wptr + (AW+1)'(1);
         if (pop) rptr <= rptr + (AW+1)'(1);
      end
   end
   always_ff @(posedge hash_clk) begin
      if (push) mem[wptr[AW-1:0]] <= push_nonce;
      for (int k = 0; k < NUM_CORES; k++)
         if (hit_reg[k] && (!slot_full[k] || move[k]))
            slot_nonce[k] <= (NONCE_BITS'(hit_cnt) << LB) | NONCE_BITS'(k);
   end
endmodule

// File: tb/tb_nonce_dispatch_ctrl.sv
// tb_nonce_dispatch_ctrl: randomized scenarios against a delay-line core model and a sorted-hit reference
module tb_nonce_dispatch_ctrl;
   localparam int NC = 2, NB = 8, PL = 4, FD = 4;
   localparam logic [31:0] MV = 32'hA41F32E7;
   logic hash_clk = 0, reset = 1, new_work = 0;
   logic [255:0] work_midstate = '0, core_midstate;
   logic [95:0] work_data = '0, core_data;
   logic [NB*NC-1:0] core_nonce;
   logic [32*NC-1:0] core_hash2;
   logic running, exhausted, overflow;
   int total = 0, bad = 0;
   bit match_set [256];
   logic [NB-1:0] pipe [NC][3];
   logic [NB-1:0] rx_q[$], exp_q[$];
   bit ok;
   nonce_dispatch_if #(.NONCE_BITS(NB)) gn();
   nonce_dispatch_ctrl #(.NUM_CORES(NC), .NONCE_BITS(NB), .PIPE_LATENCY(PL), .FIFO_DEPTH(FD),
      .MATCH_VALUE(MV)) dut (
      .hash_clk(hash_clk), .reset(reset), .new_work(new_work), .work_midstate(work_midstate),
      .work_data(work_data), .core_midstate(core_midstate), .core_data(core_data),
      .core_nonce(core_nonce), .core_hash2(core_hash2), .gn(gn), .running(running),
      .exhausted(exhausted), .overflow(overflow));
   always #5 hash_clk = ~hash_clk;
   function automatic logic [NB-1:0] lane(int k);
      return core_nonce[k*NB +: NB];
   endfunction
   // hasher stand-in: the hash for a nonce appears PL cycles after the nonce is driven
   always @(posedge hash_clk)
      for (int k = 0; k < NC; k++) begin
         pipe[k][0] <= lane(k);
         pipe[k][1] <= pipe[k][0];
         pipe[k][2] <= pipe[k][1];
         core_hash2[32*k +: 32] <= match_set[pipe[k][2]] ? MV : ~MV;
      end
   always @(negedge hash_clk)
      if (gn.gn_valid && gn.gn_ready) rx_q.push_back(gn.gn_nonce);
   task automatic tick(int n = 1);
      repeat (n) @(posedge hash_clk);
      #1;
   endtask
   task automatic clear_matches();
      foreach (match_set[j]) match_set[j] = 0;
   endtask
   task automatic start_work();
      for (int j = 0; j < 8; j++) work_midstate[32*j +: 32] = $urandom;
      for (int j = 0; j < 3; j++) work_data[32*j +: 32] = $urandom;
      new_work = 1;
      tick();
      new_work = 0;
   endtask
   // reference: hits leave in ascending nonce order; only the first `limit` survive a stalled consumer
   task automatic build_exp(input int limit);
      exp_q.delete();
      for (int n = 0; n < 256; n++)
         if (match_set[n] && exp_q.size() < limit) exp_q.push_back(NB'(n));
   endtask
   task automatic test_reset();
      gn.gn_ready = 0;
      clear_matches();
      reset = 1;
      tick(3);
      for (int p = 0; p < 2; p++) begin
         total++;
         if ({gn.gn_valid, running, exhausted, overflow} !== 4'b0) begin
            bad++;
            $display("FAIL reset_flags p=%0d got=%b exp=0000", p, {gn.gn_valid, running, exhausted, overflow});
         end
         total++;
         if (core_nonce !== 16'h0100) begin
            bad++;
            $display("FAIL reset_lanes p=%0d got=%h exp=0100", p, core_nonce);
         end
         total++;
         if (core_midstate !== '0 || core_data !== '0 || gn.gn_nonce !== '0) begin
            bad++;
            $display("FAIL reset_data p=%0d data=%h nonce=%h exp=0", p, core_data, gn.gn_nonce);
         end
         reset = 0;
         tick(20);
      end
   endtask
   task automatic test_single();
      int f5 = -1, fv = -1, pulses = 0;
      clear_matches();
      match_set[8'h05] = 1;
      gn.gn_ready = 1;
      rx_q.delete();
      start_work();
      total++;
      if (core_midstate !== work_midstate || core_data !== work_data || running !== 1 || core_nonce !== 16'h0100) begin
         bad++;
         $display("FAIL start_state running=%b lanes=%h exp running=1 lanes=0100", running, core_nonce);
      end
      for (int i = 1; i <= 30; i++) begin
         @(negedge hash_clk);
         if (f5 < 0 && lane(1) == 8'h05) f5 = i;
         if (gn.gn_valid) begin
            pulses++;
            if (fv < 0) fv = i;
         end
         tick();
      end
      total++;
      if (f5 != 3) begin
         bad++;
         $display("FAIL single_issue got_cycle=%0d exp=3", f5);
      end
      total++;
      if (fv - f5 != PL + 3) begin
         bad++;
         $display("FAIL single_latency got=%0d exp=%0d", fv - f5, PL + 3);
      end
      total++;
      if (pulses != 1 || rx_q.size() != 1 || rx_q[0] !== 8'h05) begin
         bad++;
         $display("FAIL single_report pulses=%0d got_n=%0d exp 1 pulse nonce 05", pulses, rx_q.size());
      end
   endtask
   task automatic test_same_cycle();
      int b = $urandom_range(4, 40);
      clear_matches();
      match_set[2*b] = 1;
      match_set[2*b+1] = 1;
      gn.gn_ready = 0;
      rx_q.delete();
      start_work();
      tick(60);
      total++;
      if (gn.gn_valid !== 1 || gn.gn_nonce !== NB'(2*b)) begin
         bad++;
         $display("FAIL pair_hold valid=%b nonce=%h exp 1/%h", gn.gn_valid, gn.gn_nonce, NB'(2*b));
      end
      gn.gn_ready = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge hash_clk);
         total++;
         if (gn.gn_valid !== (i < 2) || (i < 2 && gn.gn_nonce !== NB'(2*b + i))) begin
            bad++;
            $display("FAIL pair_drain i=%0d valid=%b nonce=%h exp %b/%h", i, gn.gn_valid, gn.gn_nonce, i < 2, NB'(2*b + i));
         end
         tick();
      end
   endtask
   task automatic test_end_random();
      for (int it = 0; it < 2; it++) begin
         int fall = -1, rise = -1;
         clear_matches();
         for (int c = 0; c < 127; c++)
            if ($urandom_range(5) == 0) match_set[2*c + $urandom_range(1)] = 1;
         match_set[8'hFF] = 1;
         gn.gn_ready = 1;
         rx_q.delete();
         start_work();
         for (int i = 1; i <= 160; i++) begin
            @(negedge hash_clk);
            if (fall < 0 && !running) fall = i;
            if (rise < 0 && exhausted) rise = i;
            tick();
         end
         total++;
         if (fall != (1 << (NB - 1)) + PL + 2 || rise != fall) begin
            bad++;
            $display("FAIL end_timing fall=%0d rise=%0d exp=%0d", fall, rise, (1 << (NB - 1)) + PL + 2);
         end
         total++;
         if (core_nonce !== 16'hFFFE || exhausted !== 1 || overflow !== 0) begin
            bad++;
            $display("FAIL end_state lanes=%h exh=%b ovf=%b exp FFFE/1/0", core_nonce, exhausted, overflow);
         end
         build_exp(256);
         ok = rx_q.size() == exp_q.size();
         foreach (exp_q[j]) if (ok && rx_q[j] !== exp_q[j]) ok = 0;
         total++;
         if (!ok) begin
            bad++;
            $display("FAIL end_list it=%0d got_n=%0d exp_n=%0d", it, rx_q.size(), exp_q.size());
         end
      end
   endtask
   task automatic test_overflow();
      for (int it = 0; it < 2; it++) begin
         int ln = it ? $urandom_range(1) : 0;
         int b = it ? $urandom_range(8, 40) : 8'h20;
         int n = it ? $urandom_range(6, 8) : 7;
         clear_matches();
         for (int j = 0; j < n; j++) match_set[2*(b + j) + ln] = 1;
         gn.gn_ready = 0;
         rx_q.delete();
         start_work();
         total++;
         if (exhausted !== 0 || overflow !== 0) begin
            bad++;
            $display("FAIL ovf_clear it=%0d exh=%b ovf=%b exp 0/0", it, exhausted, overflow);
         end
         tick(b + n + 15);
         total++;
         if (overflow !== (n > FD + 1) || gn.gn_valid !== 1 || gn.gn_nonce !== NB'(2*b + ln)) begin
            bad++;
            $display("FAIL ovf_stall it=%0d ovf=%b head=%h exp %b/%h", it, overflow, gn.gn_nonce, n > FD + 1, NB'(2*b + ln));
         end
         gn.gn_ready = 1;
         tick(15);
         build_exp(FD + 1);
         ok = rx_q.size() == exp_q.size();
         foreach (exp_q[j]) if (ok && rx_q[j] !== exp_q[j]) ok = 0;
         total++;
         if (!ok) begin
            bad++;
            $display("FAIL ovf_list it=%0d got_n=%0d exp_n=%0d", it, rx_q.size(), exp_q.size());
         end
      end
   endtask
   task automatic test_flush();
      clear_matches();
      match_set[8'h10] = 1;
      match_set[8'h12] = 1;
      match_set[8'h14] = 1;
      match_set[8'h36] = 1;
      gn.gn_ready = 0;
      rx_q.delete();
      start_work();
      tick(29);
      total++;
      if (gn.gn_valid !== 1 || gn.gn_nonce !== 8'h10 || overflow !== 0) begin
         bad++;
         $display("FAIL flush_pre valid=%b head=%h ovf=%b exp 1/10/0", gn.gn_valid, gn.gn_nonce, overflow);
      end
      start_work();
      total++;
      if (gn.gn_valid !== 0 || overflow !== 0 || exhausted !== 0 || running !== 1 || core_nonce !== 16'h0100) begin
         bad++;
         $display("FAIL flush_post valid=%b run=%b lanes=%h exp 0/1/0100", gn.gn_valid, running, core_nonce);
      end
      gn.gn_ready = 1;
      tick(60);
      build_exp(256);
      ok = rx_q.size() == exp_q.size();
      foreach (exp_q[j]) if (ok && rx_q[j] !== exp_q[j]) ok = 0;
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL flush_list got_n=%0d exp_n=%0d", rx_q.size(), exp_q.size());
      end
   endtask
   task automatic test_async_reset();
      clear_matches();
      match_set[8'h05] = 1;
      gn.gn_ready = 0;
      start_work();
      tick(15);
      total++;
      if (gn.gn_valid !== 1 || running !== 1) begin
         bad++;
         $display("FAIL areset_pre valid=%b run=%b exp 1/1", gn.gn_valid, running);
      end
      #2 reset = 1;
      #1;
      total++;
      if ({gn.gn_valid, running, exhausted, overflow} !== 4'b0 || core_nonce !== 16'h0100 || core_midstate !== '0 || gn.gn_nonce !== '0) begin
         bad++;
         $display("FAIL areset_now flags=%b lanes=%h exp 0000/0100", {gn.gn_valid, running, exhausted, overflow}, core_nonce);
      end
      #1 reset = 0;
      tick(2);
      gn.gn_ready = 1;
      rx_q.delete();
      start_work();
      tick(20);
      total++;
      if (rx_q.size() != 1 || rx_q[0] !== 8'h05) begin
         bad++;
         $display("FAIL areset_restart got_n=%0d exp 1 nonce 05", rx_q.size());
      end
   endtask
   initial begin
      test_reset();
      test_single();
      test_same_cycle();
      test_end_random();
      test_overflow();
      test_flush();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
